async_fifo_rd_sched: RTL and testbench

//  Read-domain controller of the async FIFO. Owns the read pointer and the empty flag.

---
 rtl/async_fifo_pkg.sv | 27 ++
 rtl/async_fifo_rd_sched_if.sv | 38 +++
 rtl/async_fifo_rr_pick.sv | 38 +++
 rtl/async_fifo_rd_sched.sv | 161 ++++++++++++++++
 tb/tb_async_fifo_rd_sched.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and pointer-code helpers for the async FIFO read domain.
package async_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } rd_state_e;

  // Helpers work on a wide container; callers zero-extend and keep the low bits.
  localparam int PTR_W_MAX = 32;
  typedef logic [PTR_W_MAX-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
    ptr_wide_t bin;
    bin = '0;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_rd_sched_if.sv
// Read-side bus of the async FIFO scheduler; the slave modport belongs to the scheduler.
// Optional level ports appear only when ASYNC_FIFO_RLEVEL_EN is defined.
interface async_fifo_rd_sched_if #(
  parameter int ADDRSIZE = 4,
  parameter int NUM_REQ  = 2
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [ADDRSIZE:0]   wptr_sync_i;
  logic [NUM_REQ-1:0]  req_i;
  logic [NUM_REQ-1:0]  gnt_o;
  logic [ADDRSIZE-1:0] raddr_o;
  logic                rd_valid_o;
  logic [IDX_W-1:0]    rd_id_o;
  logic [ADDRSIZE:0]   rptr_g_o;
  logic                rempty_o;
`ifdef ASYNC_FIFO_RLEVEL_EN
  logic [ADDRSIZE:0]   rlevel_o;
  logic                raempty_o;
`endif

  modport master (
    output wptr_sync_i, req_i,
    input  gnt_o, raddr_o, rd_valid_o, rd_id_o, rptr_g_o, rempty_o
`ifdef ASYNC_FIFO_RLEVEL_EN
    , input rlevel_o, raempty_o
`endif
  );

  modport slave (
    input  wptr_sync_i, req_i,
    output gnt_o, raddr_o, rd_valid_o, rd_id_o, rptr_g_o, rempty_o
`ifdef ASYNC_FIFO_RLEVEL_EN
    , output rlevel_o, raempty_o
`endif
  );

endinterface

// File: rtl/async_fifo_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, skipping masked-out ones.
module async_fifo_rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  input  logic [NUM_REQ-1:0] excl_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] w_masked;

  assign w_masked = req_i & ~excl_i;

  // Scan starts one past the previous winner so that winner is visited last.
  always_comb begin
    int  cand;
    logic found;
    cand  = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && w_masked[IDX_W'(cand)]) begin
        found                 = 1'b1;
        idx_o                 = IDX_W'(cand);
        gnt_o[IDX_W'(cand)]   = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/async_fifo_rd_sched.sv
// Read-domain controller of the async FIFO: read pointer, empty flag and pop scheduling.
// Define ASYNC_FIFO_RLEVEL_EN to add the registered fill level and almost-empty flag.
module async_fifo_rd_sched
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4
`ifdef ASYNC_FIFO_RLEVEL_EN
  ,
  parameter int AEMPTY_THRESH = 2
`endif
) (
  input logic                  rclk_i,
  input logic                  rrst_n_i,
  async_fifo_rd_sched_if.slave rd_if
);

  localparam int PTR_W = ADDRSIZE + 1;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  rd_state_e          r_state, w_stateNext;
  logic [IDX_W-1:0]   r_owner, w_ownerNext;
  logic [IDX_W-1:0]   r_rrLast, w_rrLastNext;
  logic [IDX_W-1:0]   w_winIdx, w_pickIdx, r_rdId;
  logic [CNT_W-1:0]   r_burstCnt, w_burstCntNext;
  logic [NUM_REQ-1:0] w_gnt, w_pickGnt, w_excl, w_ownerMask;
  logic               w_pickValid, w_pop;
  logic [PTR_W-1:0]   r_rbin, w_rbinNext, r_rptrG, w_rgrayNext;
  logic               r_rempty, r_rdValid;
  ptr_wide_t          w_grayWide;
  logic [PTR_W_MAX-PTR_W-1:0] w_unusedGrayHi;

  assign w_ownerMask = NUM_REQ'(1) << r_owner;
  // While owning, the picker only serves to hand over to someone else.
  assign w_excl      = (r_state == OWN) ? w_ownerMask : '0;

  async_fifo_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (rd_if.req_i),
    .last_i  (r_rrLast),
    .excl_i  (w_excl),
    .gnt_o   (w_pickGnt),
    .idx_o   (w_pickIdx),
    .valid_o (w_pickValid)
  );

  always_comb begin
    w_stateNext    = r_state;
    w_ownerNext    = r_owner;
    w_burstCntNext = r_burstCnt;
    w_rrLastNext   = r_rrLast;
    w_gnt          = '0;
    w_winIdx       = r_owner;
    case (r_state)
      IDLE: begin
        if (!r_rempty && w_pickValid) begin
          w_gnt          = w_pickGnt;
          w_winIdx       = w_pickIdx;
          w_stateNext    = OWN;
          w_ownerNext    = w_pickIdx;
          w_burstCntNext = CNT_W'(1);
          w_rrLastNext   = w_pickIdx;
        end
      end
      OWN: begin
        // Empty freezes ownership so the burst resumes once data arrives.
        if (!r_rempty) begin
          if (rd_if.req_i[r_owner] && (r_burstCnt < CNT_W'(MAX_BURST))) begin
            w_gnt          = w_ownerMask;
            w_burstCntNext = r_burstCnt + CNT_W'(1);
          end else if (w_pickValid) begin
            w_gnt          = w_pickGnt;
            w_winIdx       = w_pickIdx;
            w_ownerNext    = w_pickIdx;
            w_burstCntNext = CNT_W'(1);
            w_rrLastNext   = w_pickIdx;
          end else if (rd_if.req_i[r_owner]) begin
            w_gnt          = w_ownerMask;
            w_burstCntNext = CNT_W'(1);
          end else begin
            w_stateNext    = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_burstCnt <= '0;
      r_rrLast   <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state    <= w_stateNext;
      r_owner    <= w_ownerNext;
      r_burstCnt <= w_burstCntNext;
      r_rrLast   <= w_rrLastNext;
    end
  end

  assign w_pop          = |w_gnt;
  assign w_rbinNext     = r_rbin + PTR_W'(w_pop);
  assign w_grayWide     = bin2gray(PTR_W_MAX'(w_rbinNext));
  assign w_rgrayNext    = w_grayWide[PTR_W-1:0];
  assign w_unusedGrayHi = w_grayWide[PTR_W_MAX-1:PTR_W];

  // Empty compares the post-pop pointer so the final pop raises it on the same edge.
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      r_rbin    <= '0;
      r_rptrG   <= '0;
      r_rempty  <= 1'b1;
      r_rdValid <= 1'b0;
      r_rdId    <= '0;
    end else begin
      r_rbin    <= w_rbinNext;
      r_rptrG   <= w_rgrayNext;
      r_rempty  <= (w_rgrayNext == rd_if.wptr_sync_i);
      r_rdValid <= w_pop;
      if (w_pop) r_rdId <= w_winIdx;
    end
  end

`ifdef ASYNC_FIFO_RLEVEL_EN
  ptr_wide_t                  w_wbinWide;
  logic [PTR_W_MAX-PTR_W-1:0] w_unusedWbinHi;
  logic [PTR_W-1:0]           w_levelNext, r_rlevel;
  logic                       r_raempty;

  assign w_wbinWide     = gray2bin(PTR_W_MAX'(rd_if.wptr_sync_i));
  assign w_unusedWbinHi = w_wbinWide[PTR_W_MAX-1:PTR_W];
  // Level uses the post-pop pointer, so it reads zero exactly when empty is set.
  assign w_levelNext    = w_wbinWide[PTR_W-1:0] - w_rbinNext;

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      r_rlevel  <= '0;
      r_raempty <= 1'b1;
    end else begin
      r_rlevel  <= w_levelNext;
      r_raempty <= (w_levelNext <= PTR_W'(AEMPTY_THRESH));
    end
  end

  assign rd_if.rlevel_o  = r_rlevel;
  assign rd_if.raempty_o = r_raempty;
`endif

  assign rd_if.gnt_o      = w_gnt;
  assign rd_if.raddr_o    = r_rbin[ADDRSIZE-1:0];
  assign rd_if.rd_valid_o = r_rdValid;
  assign rd_if.rd_id_o    = r_rdId;
  assign rd_if.rptr_g_o   = r_rptrG;
  assign rd_if.rempty_o   = r_rempty;

endmodule

// File: tb/tb_async_fifo_rd_sched.sv
// Bench for async_fifo_rd_sched: directed scenarios plus a randomized run against a queue-count model.
module tb_async_fifo_rd_sched;

  localparam int ADDRSIZE  = 4;
  localparam int NUM_REQ   = 2;
  localparam int MAX_BURST = 4;
  localparam int PTR_W     = ADDRSIZE + 1;

  logic rclk_i   = 1'b0;
  logic rrst_n_i = 1'b0;
  int   nChecks  = 0;
  int   nPass    = 0;

  // Model state: total writes/pops seen, current owner (-1 = none), run length, last winner.
  int   m_wr, m_rd, m_owner, m_run, m_last, m_id;
  logic m_empty, m_valid;

  async_fifo_rd_sched_if #(.ADDRSIZE(ADDRSIZE), .NUM_REQ(NUM_REQ)) rdIf ();

  async_fifo_rd_sched #(
    .ADDRSIZE  (ADDRSIZE),
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .rclk_i   (rclk_i),
    .rrst_n_i (rrst_n_i),
    .rd_if    (rdIf)
  );

  always #5 rclk_i = ~rclk_i;

  function automatic logic [PTR_W-1:0] grayOf(input int count);
    int b;
    b = count % 32;
    return PTR_W'(b ^ (b >> 1));
  endfunction

  function automatic bit reqBit(input logic [1:0] r, input int i);
    return ((int'(r) >> i) & 1) == 1;
  endfunction

  task automatic applyStimulus(input logic [1:0] req, input int wrCount);
    rdIf.req_i       = req;
    rdIf.wptr_sync_i = grayOf(wrCount);
  endtask

  task automatic nextCycle();
    @(posedge rclk_i);
    #1;
  endtask

  task automatic modelReset();
    m_wr = 0; m_rd = 0; m_owner = -1; m_run = 0; m_last = NUM_REQ - 1; m_id = 0;
    m_empty = 1'b1; m_valid = 1'b0;
  endtask

  task automatic doReset();
    rrst_n_i = 1'b0;
    applyStimulus(2'b00, 0);
    repeat (2) @(posedge rclk_i);
    #1;
    rrst_n_i = 1'b1;
    modelReset();
  endtask

  // Who should be granted now: keep a non-exhausted owner, else next requester round-robin.
  function automatic int modelPick(input logic [1:0] req);
    if (m_empty) return -1;
    if (m_owner >= 0 && reqBit(req, m_owner) && m_run < MAX_BURST) return m_owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (m_last + k) % NUM_REQ;
      if (c != m_owner && reqBit(req, c)) return c;
    end
    if (m_owner >= 0 && reqBit(req, m_owner)) return m_owner;
    return -1;
  endfunction

  task automatic modelAdvance(input int g);
    if (g >= 0) begin
      if (g == m_owner && m_run < MAX_BURST) m_run = m_run + 1;
      else m_run = 1;
      m_owner = g; m_last = g; m_id = g; m_valid = 1'b1;
      m_rd = m_rd + 1;
    end else begin
      m_valid = 1'b0;
      if (!m_empty) m_owner = -1;
    end
    m_empty = (m_wr == m_rd);
  endtask

  task automatic test_reset();
    doReset();
    applyStimulus(2'b11, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge rclk_i);
      nChecks++; if (rdIf.gnt_o !== 2'b00) $display("[TB] FAIL reset_gnt c%0d got=%b exp=00", k, rdIf.gnt_o); else nPass++;
      nChecks++; if (rdIf.rempty_o !== 1'b1) $display("[TB] FAIL reset_empty c%0d got=%b exp=1", k, rdIf.rempty_o); else nPass++;
      nChecks++; if (rdIf.rd_valid_o !== 1'b0) $display("[TB] FAIL reset_valid c%0d got=%b exp=0", k, rdIf.rd_valid_o); else nPass++;
      nChecks++; if (rdIf.rptr_g_o !== 5'd0) $display("[TB] FAIL reset_rptr c%0d got=%h exp=0", k, rdIf.rptr_g_o); else nPass++;
      nextCycle();
    end
    nChecks++; if (rdIf.rd_id_o !== 1'b0) $display("[TB] FAIL reset_id got=%b exp=0", rdIf.rd_id_o); else nPass++;
    nChecks++; if (rdIf.raddr_o !== 4'd0) $display("[TB] FAIL reset_raddr got=%h exp=0", rdIf.raddr_o); else nPass++;
  endtask

  task automatic test_three_entries();
    logic [1:0] expGnt  [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [3:0] expAddr [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
    logic       expVal  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       expEmp  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    doReset();
    applyStimulus(2'b01, 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge rclk_i);
      nChecks++; if (rdIf.gnt_o !== expGnt[k]) $display("[TB] FAIL three_gnt c%0d got=%b exp=%b", k, rdIf.gnt_o, expGnt[k]); else nPass++;
      nChecks++; if (rdIf.raddr_o !== expAddr[k]) $display("[TB] FAIL three_raddr c%0d got=%0d exp=%0d", k, rdIf.raddr_o, expAddr[k]); else nPass++;
      nChecks++; if (rdIf.rd_valid_o !== expVal[k]) $display("[TB] FAIL three_valid c%0d got=%b exp=%b", k, rdIf.rd_valid_o, expVal[k]); else nPass++;
      nChecks++; if (rdIf.rempty_o !== expEmp[k]) $display("[TB] FAIL three_empty c%0d got=%b exp=%b", k, rdIf.rempty_o, expEmp[k]); else nPass++;
      nextCycle();
    end
  endtask

  task automatic test_burst_pattern();
    int pat [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic [1:0] eg;
    doReset();
    applyStimulus(2'b11, 10);
    for (int k = 0; k < 12; k++) begin
      @(negedge rclk_i);
      eg = (k >= 1 && k <= 10) ? 2'(1 << pat[k-1]) : 2'b00;
      nChecks++; if (rdIf.gnt_o !== eg) $display("[TB] FAIL burst_gnt c%0d got=%b exp=%b", k, rdIf.gnt_o, eg); else nPass++;
      if (k >= 2) begin
        nChecks++; if (rdIf.rd_valid_o !== 1'b1) $display("[TB] FAIL burst_valid c%0d got=%b exp=1", k, rdIf.rd_valid_o); else nPass++;
        nChecks++; if (rdIf.rd_id_o !== 1'(pat[k-2])) $display("[TB] FAIL burst_id c%0d got=%0d exp=%0d", k, rdIf.rd_id_o, pat[k-2]); else nPass++;
      end
      nextCycle();
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(2'b11, 8);
    repeat (3) nextCycle();
    applyStimulus(2'b10, 8);
    for (int k = 3; k < 5; k++) begin
      @(negedge rclk_i);
      nChecks++; if (rdIf.gnt_o !== 2'b10) $display("[TB] FAIL handover_gnt c%0d got=%b exp=10", k, rdIf.gnt_o); else nPass++;
      nChecks++; if (rdIf.raddr_o !== 4'(k - 1)) $display("[TB] FAIL handover_raddr c%0d got=%0d exp=%0d", k, rdIf.raddr_o, k - 1); else nPass++;
      nextCycle();
    end
  endtask

  task automatic test_wrap();
    int wrTarget [2] = '{16, 31};
    int expGrants [2] = '{16, 15};
    doReset();
    for (int p = 0; p < 2; p++) begin
      int grants, emptyAt;
      grants = 0; emptyAt = -1;
      applyStimulus(2'b01, wrTarget[p]);
      for (int k = 0; k < 40; k++) begin
        @(negedge rclk_i);
        if (rdIf.gnt_o !== 2'b00) grants++;
        if (k > 0 && rdIf.rempty_o === 1'b1) begin
          emptyAt = k;
          break;
        end
        nextCycle();
      end
      nChecks++; if (grants != expGrants[p]) $display("[TB] FAIL drain_grants p%0d got=%0d exp=%0d", p, grants, expGrants[p]); else nPass++;
      nChecks++; if (emptyAt != expGrants[p] + 1) $display("[TB] FAIL drain_cycles p%0d got=%0d exp=%0d", p, emptyAt, expGrants[p] + 1); else nPass++;
      nextCycle();
    end
    nChecks++; if (rdIf.raddr_o !== 4'd15) $display("[TB] FAIL prewrap_raddr got=%0d exp=15", rdIf.raddr_o); else nPass++;
    nChecks++; if (rdIf.rptr_g_o !== 5'b10000) $display("[TB] FAIL prewrap_rptr got=%b exp=10000", rdIf.rptr_g_o); else nPass++;
    applyStimulus(2'b01, 32);
    @(negedge rclk_i);
    nChecks++; if (rdIf.gnt_o !== 2'b00) $display("[TB] FAIL wrap_stale_gnt got=%b exp=00", rdIf.gnt_o); else nPass++;
    nextCycle();
    @(negedge rclk_i);
    nChecks++; if (rdIf.gnt_o !== 2'b01) $display("[TB] FAIL wrap_gnt got=%b exp=01", rdIf.gnt_o); else nPass++;
    nChecks++; if (rdIf.raddr_o !== 4'd15) $display("[TB] FAIL wrap_raddr got=%0d exp=15", rdIf.raddr_o); else nPass++;
    nextCycle();
    @(negedge rclk_i);
    nChecks++; if (rdIf.rptr_g_o !== 5'd0) $display("[TB] FAIL wrap_rptr got=%b exp=00000", rdIf.rptr_g_o); else nPass++;
    nChecks++; if (rdIf.rempty_o !== 1'b1) $display("[TB] FAIL wrap_empty got=%b exp=1", rdIf.rempty_o); else nPass++;
    nChecks++; if (rdIf.raddr_o !== 4'd0) $display("[TB] FAIL wrap_raddr0 got=%0d exp=0", rdIf.raddr_o); else nPass++;
    nChecks++; if (rdIf.gnt_o !== 2'b00) $display("[TB] FAIL wrap_gnt0 got=%b exp=00", rdIf.gnt_o); else nPass++;
    nextCycle();
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    applyStimulus(2'b11, 8);
    repeat (2) nextCycle();
    @(negedge rclk_i);
    nChecks++; if (rdIf.rd_valid_o !== 1'b1) $display("[TB] FAIL midrst_inflight got=%b exp=1", rdIf.rd_valid_o); else nPass++;
    #1 rrst_n_i = 1'b0;
    #1;
    nChecks++; if (rdIf.gnt_o !== 2'b00) $display("[TB] FAIL midrst_gnt got=%b exp=00", rdIf.gnt_o); else nPass++;
    nChecks++; if (rdIf.rd_valid_o !== 1'b0) $display("[TB] FAIL midrst_valid got=%b exp=0", rdIf.rd_valid_o); else nPass++;
    nChecks++; if (rdIf.raddr_o !== 4'd0) $display("[TB] FAIL midrst_raddr got=%0d exp=0", rdIf.raddr_o); else nPass++;
    nextCycle();
    rrst_n_i = 1'b1;
    @(negedge rclk_i);
    nChecks++; if (rdIf.gnt_o !== 2'b00) $display("[TB] FAIL postrst_gnt0 got=%b exp=00", rdIf.gnt_o); else nPass++;
    nextCycle();
    @(negedge rclk_i);
    nChecks++; if (rdIf.gnt_o !== 2'b01) $display("[TB] FAIL postrst_gnt got=%b exp=01", rdIf.gnt_o); else nPass++;
    nextCycle();
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [1:0] eg;
    int g;
    doReset();
    req = 2'b00;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) < 3) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 4) m_wr = m_wr + int'($urandom_range(1, 3));
      if (m_wr > m_rd + 16) m_wr = m_rd + 16;
      applyStimulus(req, m_wr);
      @(negedge rclk_i);
      g  = modelPick(req);
      eg = (g < 0) ? 2'b00 : 2'(1 << g);
      nChecks++; if (rdIf.gnt_o !== eg) $display("[TB] FAIL rnd_gnt c%0d got=%b exp=%b", k, rdIf.gnt_o, eg); else nPass++;
      nChecks++; if (rdIf.raddr_o !== 4'(m_rd % 16)) $display("[TB] FAIL rnd_raddr c%0d got=%0d exp=%0d", k, rdIf.raddr_o, m_rd % 16); else nPass++;
      nChecks++; if (rdIf.rempty_o !== m_empty) $display("[TB] FAIL rnd_empty c%0d got=%b exp=%b", k, rdIf.rempty_o, m_empty); else nPass++;
      nChecks++; if (rdIf.rptr_g_o !== grayOf(m_rd)) $display("[TB] FAIL rnd_rptr c%0d got=%b exp=%b", k, rdIf.rptr_g_o, grayOf(m_rd)); else nPass++;
      nChecks++; if (rdIf.rd_valid_o !== m_valid) $display("[TB] FAIL rnd_valid c%0d got=%b exp=%b", k, rdIf.rd_valid_o, m_valid); else nPass++;
      if (m_valid) begin
        nChecks++; if (rdIf.rd_id_o !== 1'(m_id)) $display("[TB] FAIL rnd_id c%0d got=%0d exp=%0d", k, rdIf.rd_id_o, m_id); else nPass++;
      end
      @(posedge rclk_i);
      #1;
      modelAdvance(g);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d passed=%0d", nChecks, nPass);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_three_entries();
    test_burst_pattern();
    test_back_to_back();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
